// File: rtl/pipo_share_arb_pkg.sv
// Shared types and constants for the round-robin shared PIPO register arbiter.
// Holds the FSM encoding, default sizes and the pointer-width helper.
package pipo_arb_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_HOLD  = 2;

  // Wide enough for HOLD-1 with HOLD up to 15
  localparam int CNT_W = 4;

  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipo_share_arb_if.sv
// Requester/consumer bundle of the shared PIPO arbiter.
// The master side drives requests and words; the slave side is the arbiter.
interface pipo_share_arb_if #(
  parameter int NREQ  = pipo_arb_pkg::DEF_NREQ,
  parameter int WIDTH = pipo_arb_pkg::DEF_WIDTH
) ();
  localparam int OW = pipo_arb_pkg::ptr_w(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      y;
  logic                  y_valid;
  logic [OW-1:0]         owner;
  logic                  busy;

  modport master (
    output req, din,
    input  ack, y, y_valid, owner, busy
  );

  modport slave (
    input  req, din,
    output ack, y, y_valid, owner, busy
  );
endinterface

// File: rtl/pipo_share_arb_rr_pick.sv
// Combinational round-robin pick: first set req bit scanning upward from
// last+1 with wrap-around; any_req flags that some request is present.
module rr_pick
  import pipo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [ptr_w(NREQ)-1:0]  last,
  output logic [ptr_w(NREQ)-1:0]  winner,
  output logic                    any_req
);
  localparam int OW = ptr_w(NREQ);

  logic [OW-1:0] idx;

  // Scan from the farthest slot down to last+1 so the nearest hit wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = OW'((int'(last) + k) % NREQ);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipo_share_arb.sv
// Round-robin arbiter sharing one WIDTH-bit holding register among NREQ
// requesters; a loaded word is held stable for HOLD cycles before re-arbitration.
module pipo_share_arb
  import pipo_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int HOLD  = DEF_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  pipo_share_arb_if.slave   bus
);
  localparam int OW = ptr_w(NREQ);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [OW-1:0]     last, winner, owner_q;
  logic              any_req, load;
  logic [WIDTH-1:0]  y_q, word;
  logic [NREQ-1:0]   ack_q;
  logic              valid_q;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req),
    .last    (last),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    word = bus.din[int'(winner)*WIDTH +: WIDTH];
  end

  // Requests are only looked at in IDLE; HOLD ignores req entirely.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          load      = 1'b1;
          state_nxt = S_HOLD;
          cnt_nxt   = CNT_W'(HOLD - 1);
        end
      end
      S_HOLD: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ack is a single-cycle pulse: cleared every edge unless a load happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
      owner_q <= '0;
      last    <= OW'(NREQ - 1);
    end else begin
      ack_q <= '0;
      if (load) begin
        y_q           <= word;
        ack_q[winner] <= 1'b1;
        owner_q       <= winner;
        last          <= winner;
        valid_q       <= 1'b1;
      end
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = valid_q;
  assign bus.ack     = ack_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = (state == S_HOLD);

endmodule

// File: tb/tb_pipo_share_arb.sv
// Bench for pipo_share_arb: directed vector table, async-reset sequence and
// randomized traffic checked against a behavioural round-robin model.
module tb_pipo_share_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int HOLD  = 2;

  logic clk;
  logic rst;
  int   tests = 0;
  int   errs  = 0;

  pipo_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  pipo_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  y;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        valid;
    logic        busy;
  } vec_t;

  vec_t vt[$];

  // Model: busy_left counts the remaining hold cycles after an edge.
  int m_y, m_ack, m_owner, m_valid, m_left, m_last;

  task automatic model_reset();
    m_y = 0; m_ack = 0; m_owner = 0; m_valid = 0; m_left = 0; m_last = NREQ - 1;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] q, input logic [15:0] d);
    int w;
    if (r) begin
      model_reset();
      return;
    end
    m_ack = 0;
    if (m_left > 0) begin
      m_left--;
    end else if (q != 0) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && q[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
      m_y     = (d >> (w * WIDTH)) & 'hF;
      m_ack   = 1 << w;
      m_owner = w;
      m_last  = w;
      m_valid = 1;
      m_left  = HOLD;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] y, input logic [3:0] a,
                           input logic [1:0] o, input logic v, input logic b);
    check({tag, ".y"},       32'(bus.y),       32'(y));
    check({tag, ".ack"},     32'(bus.ack),     32'(a));
    check({tag, ".owner"},   32'(bus.owner),   32'(o));
    check({tag, ".y_valid"}, 32'(bus.y_valid), 32'(v));
    check({tag, ".busy"},    32'(bus.busy),    32'(b));
  endtask

  // Drive at the negedge, let one posedge happen, return at the next negedge.
  task automatic apply(input logic r, input logic [3:0] q, input logic [15:0] d);
    rst     = r;
    bus.req = q;
    bus.din = d;
    @(posedge clk);
    model_edge(r, q, d);
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic [15:0] d,
                     input logic [3:0] y, input logic [3:0] a, input logic [1:0] o,
                     input logic v, input logic b);
    vec_t e;
    e.rst = r; e.req = q; e.din = d; e.y = y; e.ack = a; e.owner = o; e.valid = v; e.busy = b;
    vt.push_back(e);
  endtask

  initial begin
    rst     = 1'b1;
    bus.req = '0;
    bus.din = '0;
    model_reset();

    // reset with requests asserted
    add(1, 4'hF, 16'h0000, 4'h0, 4'h0, 2'd0, 0, 0);
    add(1, 4'hF, 16'h0000, 4'h0, 4'h0, 2'd0, 0, 0);
    // single requester 2, regrant after HOLD+1
    add(0, 4'h4, 16'h0A00, 4'hA, 4'h4, 2'd2, 1, 1);
    add(0, 4'h4, 16'h0A00, 4'hA, 4'h0, 2'd2, 1, 1);
    add(0, 4'h4, 16'h0A00, 4'hA, 4'h0, 2'd2, 1, 0);
    add(0, 4'h4, 16'h0A00, 4'hA, 4'h4, 2'd2, 1, 1);
    add(0, 4'h0, 16'h0000, 4'hA, 4'h0, 2'd2, 1, 1);
    add(0, 4'h0, 16'h0000, 4'hA, 4'h0, 2'd2, 1, 0);
    add(0, 4'h0, 16'h0000, 4'hA, 4'h0, 2'd2, 1, 0);
    // all requesters from reset: 1,2,3,4,1
    add(1, 4'h0, 16'h0000, 4'h0, 4'h0, 2'd0, 0, 0);
    add(0, 4'hF, 16'h4321, 4'h1, 4'h1, 2'd0, 1, 1);
    add(0, 4'hF, 16'h4321, 4'h1, 4'h0, 2'd0, 1, 1);
    add(0, 4'hF, 16'h4321, 4'h1, 4'h0, 2'd0, 1, 0);
    add(0, 4'hF, 16'h4321, 4'h2, 4'h2, 2'd1, 1, 1);
    add(0, 4'hF, 16'h4321, 4'h2, 4'h0, 2'd1, 1, 1);
    add(0, 4'hF, 16'h4321, 4'h2, 4'h0, 2'd1, 1, 0);
    add(0, 4'hF, 16'h4321, 4'h3, 4'h4, 2'd2, 1, 1);
    add(0, 4'hF, 16'h4321, 4'h3, 4'h0, 2'd2, 1, 1);
    add(0, 4'hF, 16'h4321, 4'h3, 4'h0, 2'd2, 1, 0);
    add(0, 4'hF, 16'h4321, 4'h4, 4'h8, 2'd3, 1, 1);
    add(0, 4'hF, 16'h4321, 4'h4, 4'h0, 2'd3, 1, 1);
    add(0, 4'hF, 16'h4321, 4'h4, 4'h0, 2'd3, 1, 0);
    add(0, 4'hF, 16'h4321, 4'h1, 4'h1, 2'd0, 1, 1);
    // wrap: grant 3, then 1001 -> 0, 3
    add(0, 4'h8, 16'h4321, 4'h1, 4'h0, 2'd0, 1, 1);
    add(0, 4'h8, 16'h4321, 4'h1, 4'h0, 2'd0, 1, 0);
    add(0, 4'h8, 16'h4321, 4'h4, 4'h8, 2'd3, 1, 1);
    add(0, 4'h9, 16'h4321, 4'h4, 4'h0, 2'd3, 1, 1);
    add(0, 4'h9, 16'h4321, 4'h4, 4'h0, 2'd3, 1, 0);
    add(0, 4'h9, 16'h4321, 4'h1, 4'h1, 2'd0, 1, 1);
    add(0, 4'h9, 16'h4321, 4'h1, 4'h0, 2'd0, 1, 1);
    add(0, 4'h9, 16'h4321, 4'h1, 4'h0, 2'd0, 1, 0);
    add(0, 4'h9, 16'h4321, 4'h4, 4'h8, 2'd3, 1, 1);
    // req changes during HOLD are ignored until IDLE
    add(0, 4'h2, 16'h4321, 4'h4, 4'h0, 2'd3, 1, 1);
    add(0, 4'h2, 16'h4321, 4'h4, 4'h0, 2'd3, 1, 0);
    add(0, 4'h2, 16'h4321, 4'h2, 4'h2, 2'd1, 1, 1);
    add(0, 4'h1, 16'h4325, 4'h2, 4'h0, 2'd1, 1, 1);
    add(0, 4'h1, 16'h4325, 4'h2, 4'h0, 2'd1, 1, 0);
    add(0, 4'h1, 16'h4325, 4'h5, 4'h1, 2'd0, 1, 1);

    @(negedge clk);
    foreach (vt[i]) begin
      apply(vt[i].rst, vt[i].req, vt[i].din);
      check_out($sformatf("vec%0d", i), vt[i].y, vt[i].ack, vt[i].owner, vt[i].valid, vt[i].busy);
    end

    // async reset while ack is pending in HOLD
    apply(0, 4'h0, 16'h0000);
    apply(0, 4'h0, 16'h0000);
    apply(0, 4'h1, 16'h000C);
    check_out("load_c", 4'hC, 4'h1, 2'd0, 1, 1);
    #2 rst = 1'b1;
    #1 check_out("async_rst", 4'h0, 4'h0, 2'd0, 0, 0);
    model_reset();
    @(negedge clk);
    apply(1, 4'h8, 16'h7000);
    check_out("rst_held", 4'h0, 4'h0, 2'd0, 0, 0);
    apply(0, 4'h8, 16'h7000);
    check_out("post_rst", 4'h7, 4'h8, 2'd3, 1, 1);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic       r;
      logic [3:0] q;
      r = ($urandom_range(0, 59) == 0);
      q = ($urandom_range(0, 9) < 3) ? 4'h0 : 4'($urandom);
      apply(r, q, 16'($urandom));
      check_out($sformatf("rnd%0d", c), 4'(m_y), 4'(m_ack), 2'(m_owner), m_valid[0], m_left > 0);
      check($sformatf("rnd%0d.onehot", c), 32'($onehot0(bus.ack)), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
